// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single ram256x8 MOV/MOC port between the instruction-fetch
//   requester and the load/store (data) requester. One access at a time,
//   round-robin on conflict, one-cycle ACK pulses, and a MOC timeout guard
//   that aborts a hung access and flags it on ERR.
// Ports
//   CLK, RESET                 clock, synchronous active-high reset
//   IF_REQ/IF_ADDR             fetch request and address (held until IF_ACK)
//   IF_ACK/IF_DATA             fetch done pulse, last fetched word
//   D_REQ/D_RW/D_MS/D_ADDR/D_WDATA  data request (RW 1 = load), size, addr, store data
//   D_ACK/D_RDATA              data done pulse, last load result
//   ERR                        pulses with an ACK when the access timed out
//   BUSY                       high whenever the FSM is not idle
//   MEM_MOV/RW/MS/ADDR/DIN     registered RAM command
//   MEM_MOC/MEM_DOUT           RAM completion and read data
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [2:0]  IF_MS   = 3'b010
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic        IF_ACK,
  output logic [31:0] IF_DATA,
  input  logic        D_REQ,
  input  logic        D_RW,
  input  logic [2:0]  D_MS,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic        D_ACK,
  output logic [31:0] D_RDATA,
  output logic        ERR,
  output logic        BUSY,
  output logic        MEM_MOV,
  output logic        MEM_RW,
  output logic [2:0]  MEM_MS,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_DIN,
  input  logic        MEM_MOC,
  input  logic [31:0] MEM_DOUT
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          last_d;   // 1 = data port had the most recent grant
  logic          grant_d;  // requester owning the current access
  logic [CW-1:0] acc_cnt;
  logic          pick_d;

  // Lone requester wins; on a tie the port that did not go last wins.
  always_comb begin
    pick_d = D_REQ && (!IF_REQ || !last_d);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      grant_d  <= 1'b0;
      acc_cnt  <= '0;
      IF_ACK   <= 1'b0;
      IF_DATA  <= '0;
      D_ACK    <= 1'b0;
      D_RDATA  <= '0;
      ERR      <= 1'b0;
      BUSY     <= 1'b0;
      MEM_MOV  <= 1'b0;
      MEM_RW   <= 1'b0;
      MEM_MS   <= '0;
      MEM_ADDR <= '0;
      MEM_DIN  <= '0;
    end else begin
      IF_ACK <= 1'b0;
      D_ACK  <= 1'b0;
      ERR    <= 1'b0;
      case (state)
        IDLE: begin
          if (IF_REQ || D_REQ) begin
            grant_d <= pick_d;
            last_d  <= pick_d;
            MEM_MOV <= 1'b1;
            acc_cnt <= '0;
            BUSY    <= 1'b1;
            state   <= ACCESS;
            if (pick_d) begin
              MEM_RW   <= D_RW;
              MEM_MS   <= D_MS;
              MEM_ADDR <= D_ADDR;
              MEM_DIN  <= D_WDATA;
            end else begin
              MEM_RW   <= 1'b1;
              MEM_MS   <= IF_MS;
              MEM_ADDR <= IF_ADDR;
              MEM_DIN  <= '0;
            end
          end
        end
        ACCESS: begin
          if (MEM_MOC) begin
            if (MEM_RW) begin
              if (grant_d) D_RDATA <= MEM_DOUT;
              else         IF_DATA <= MEM_DOUT;
            end
            IF_ACK  <= !grant_d;
            D_ACK   <= grant_d;
            MEM_MOV <= 1'b0;
            state   <= RECOVER;
          end else if (acc_cnt == CNT_LAST) begin
            // Abort: requester is released with ERR, read data left untouched.
            IF_ACK  <= !grant_d;
            D_ACK   <= grant_d;
            ERR     <= 1'b1;
            MEM_MOV <= 1'b0;
            state   <= RECOVER;
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
          end
        end
        RECOVER: begin
          // Hold MOV low until the RAM has released MOC.
          if (!MEM_MOC) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          BUSY    <= 1'b0;
          MEM_MOV <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam logic [31:0] K = 32'hE1A0800C;  // RAM model: DOUT = ADDR ^ K

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IF_REQ = 1'b0;
  logic [31:0] IF_ADDR = '0;
  logic        IF_ACK;
  logic [31:0] IF_DATA;
  logic        D_REQ = 1'b0;
  logic        D_RW = 1'b0;
  logic [2:0]  D_MS = '0;
  logic [31:0] D_ADDR = '0;
  logic [31:0] D_WDATA = '0;
  logic        D_ACK;
  logic [31:0] D_RDATA;
  logic        ERR;
  logic        BUSY;
  logic        MEM_MOV;
  logic        MEM_RW;
  logic [2:0]  MEM_MS;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_DIN;
  logic        MEM_MOC = 1'b0;
  logic [31:0] MEM_DOUT = '0;

  mem_port_arbiter #(.TIMEOUT(16), .IF_MS(3'b010)) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK), .IF_DATA(IF_DATA),
    .D_REQ(D_REQ), .D_RW(D_RW), .D_MS(D_MS), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA), .ERR(ERR), .BUSY(BUSY),
    .MEM_MOV(MEM_MOV), .MEM_RW(MEM_RW), .MEM_MS(MEM_MS), .MEM_ADDR(MEM_ADDR),
    .MEM_DIN(MEM_DIN), .MEM_MOC(MEM_MOC), .MEM_DOUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        src;     // 0 = fetch, 1 = data
    logic        err;
    logic [31:0] addr;
    logic        rw;
    logic [2:0]  ms;
    logic [31:0] din;
    logic [31:0] data;    // IF_DATA or D_RDATA seen with the ACK
    logic [7:0]  movlen;  // cycles MOV was high
    logic        stable;  // MEM_* unchanged while MOV high
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] exp_if_data = '0;
  logic [31:0] exp_d_rdata = '0;

  // RAM model: MOC after ram_lat MOV-high cycles, optionally held ram_hold
  // cycles after MOV drops; ram_dead never answers.
  int ram_lat = 3;
  int ram_hold = 0;
  bit ram_dead = 1'b0;
  int mcnt = 0;
  int hold_left = 0;

  always @(negedge CLK) begin
    if (!MEM_MOV) begin
      mcnt = 0;
      if (hold_left > 0) hold_left--;
      else MEM_MOC = 1'b0;
    end else if (!ram_dead) begin
      mcnt++;
      if (mcnt >= ram_lat) begin
        if (!MEM_MOC) hold_left = ram_hold;
        MEM_MOC  = 1'b1;
        MEM_DOUT = MEM_ADDR ^ K;
      end
    end
  end

  // Bus monitor: captures the command at MOV rise and tracks its length.
  logic        prev_mov = 1'b0;
  logic [31:0] mon_addr = '0;
  logic [31:0] mon_din = '0;
  logic        mon_rw = 1'b0;
  logic [2:0]  mon_ms = '0;
  logic [7:0]  mon_len = '0;
  logic        mon_stable = 1'b0;

  always @(negedge CLK) begin
    if (MEM_MOV) begin
      if (!prev_mov) begin
        mon_addr = MEM_ADDR; mon_din = MEM_DIN; mon_rw = MEM_RW; mon_ms = MEM_MS;
        mon_len = 8'd1; mon_stable = 1'b1;
      end else begin
        mon_len = mon_len + 8'd1;
        if ({MEM_ADDR, MEM_DIN, MEM_RW, MEM_MS} !== {mon_addr, mon_din, mon_rw, mon_ms})
          mon_stable = 1'b0;
      end
    end
    prev_mov = MEM_MOV;
  end

  function automatic rec_t mk(input logic src, input logic err, input logic [31:0] addr,
                              input logic rw, input logic [2:0] ms, input logic [31:0] din,
                              input logic [31:0] data, input int len);
    rec_t r;
    r.src = src; r.err = err; r.addr = addr; r.rw = rw; r.ms = ms; r.din = din;
    r.data = data; r.movlen = 8'(len); r.stable = 1'b1;
    return r;
  endfunction

  function automatic string fmt(input rec_t r);
    return $sformatf("src=%0d err=%0d addr=%h rw=%0d ms=%b din=%h data=%h mov=%0d stable=%0d",
                     r.src, r.err, r.addr, r.rw, r.ms, r.din, r.data, r.movlen, r.stable);
  endfunction

  // Requester side: waits for n ACKs, records each, drops REQ on its ACK
  // unless asked to keep re-requesting.
  task automatic serve(input int n, input bit keep_if, input bit keep_d);
    int got = 0;
    int cyc = 0;
    rec_t o;
    while (got < n && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (IF_ACK || D_ACK) begin
        o.src = D_ACK; o.err = ERR; o.addr = mon_addr; o.rw = mon_rw; o.ms = mon_ms;
        o.din = mon_din; o.data = D_ACK ? D_RDATA : IF_DATA; o.movlen = mon_len;
        o.stable = mon_stable;
        obs_q.push_back(o);
        got++;
        if (got >= n) begin
          IF_REQ = 1'b0; D_REQ = 1'b0;
        end else begin
          if (IF_ACK && !keep_if) IF_REQ = 1'b0;
          if (D_ACK && !keep_d) D_REQ = 1'b0;
        end
      end
    end
    if (got < n) begin
      vectors++; miscompares++;
      $display("FAIL ack_wait: acks seen %0d required %0d", got, n);
      IF_REQ = 1'b0; D_REQ = 1'b0;
      while (got < n) begin obs_q.push_back('1); got++; end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    vectors++;
    if ({IF_ACK, IF_DATA, D_ACK, D_RDATA, ERR, BUSY, MEM_MOV, MEM_RW, MEM_MS, MEM_ADDR, MEM_DIN} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got mov=%0d busy=%0d ack=%0d/%0d addr=%h required all zero",
               MEM_MOV, BUSY, IF_ACK, D_ACK, MEM_ADDR);
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_fetch();
    rec_t e, o;
    ram_lat = 3;
    IF_ADDR = 32'h0;
    IF_REQ = 1'b1;
    exp_if_data = 32'h0 ^ K;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 3'b010, 32'h0, exp_if_data, 3));
    serve(1, 1'b0, 1'b0);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL fetch: got %s required %s", fmt(o), fmt(e));
    end
    @(negedge CLK);
    vectors++;
    if (BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_busy_after_recover: got %0d required 0", BUSY);
    end
  endtask

  task automatic test_store();
    rec_t e, o;
    int extra = 0;
    ram_lat = 2;
    D_RW = 1'b0; D_ADDR = 32'h40; D_WDATA = 32'hDEADBEEF; D_MS = 3'b001;
    D_REQ = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h40, 1'b0, 3'b001, 32'hDEADBEEF, exp_d_rdata, 2));
    serve(1, 1'b0, 1'b0);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL store: got %s required %s", fmt(o), fmt(e));
    end
    repeat (6) begin
      @(negedge CLK);
      if (IF_ACK || D_ACK || MEM_MOV) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL store_single_ack: got %0d extra cycles of activity required 0", extra);
    end
  endtask

  task automatic test_round_robin();
    rec_t e, o;
    ram_lat = 1;
    IF_ADDR = 32'h100;
    D_RW = 1'b1; D_ADDR = 32'h200; D_MS = 3'b010; D_WDATA = 32'h0BAD0BAD;
    exp_if_data = 32'h100 ^ K;
    exp_d_rdata = 32'h200 ^ K;
    for (int unsigned i = 0; i < 2; i++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 32'h100, 1'b1, 3'b010, 32'h0, exp_if_data, 1));
      exp_q.push_back(mk(1'b1, 1'b0, 32'h200, 1'b1, 3'b010, 32'h0BAD0BAD, exp_d_rdata, 1));
    end
    IF_REQ = 1'b1; D_REQ = 1'b1;
    serve(4, 1'b1, 1'b1);
    for (int unsigned i = 0; i < 4; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL round_robin[%0d]: got %s required %s", i, fmt(o), fmt(e));
      end
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_timeout();
    rec_t e, o;
    ram_dead = 1'b1;
    D_RW = 1'b1; D_ADDR = 32'h300; D_MS = 3'b000; D_WDATA = 32'h11112222;
    D_REQ = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b1, 32'h300, 1'b1, 3'b000, 32'h11112222, exp_d_rdata, 16));
    serve(1, 1'b0, 1'b0);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL timeout: got %s required %s", fmt(o), fmt(e));
    end
    ram_dead = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset_mid_access();
    rec_t e, o;
    int w = 0;
    int acks = 0;
    ram_dead = 1'b1;
    D_RW = 1'b1; D_ADDR = 32'h44; D_MS = 3'b010; D_WDATA = 32'h0;
    D_REQ = 1'b1;
    do begin @(negedge CLK); w++; end while (!MEM_MOV && w < 20);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    D_REQ = 1'b0;
    exp_if_data = '0;
    exp_d_rdata = '0;
    vectors++;
    if ({MEM_MOV, D_ACK, ERR, BUSY} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_mid_access: got mov=%0d ack=%0d err=%0d busy=%0d required 0 0 0 0",
               MEM_MOV, D_ACK, ERR, BUSY);
    end
    ram_dead = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (D_ACK || IF_ACK || MEM_MOV) acks++;
    end
    vectors++;
    if (acks !== 0) begin
      miscompares++;
      $display("FAIL reset_no_ack: got %0d active cycles required 0", acks);
    end
    ram_lat = 2;
    IF_ADDR = 32'h8;
    D_RW = 1'b1; D_ADDR = 32'h48; D_MS = 3'b001; D_WDATA = 32'h5A5A5A5A;
    exp_if_data = 32'h8 ^ K;
    exp_d_rdata = 32'h48 ^ K;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h8, 1'b1, 3'b010, 32'h0, exp_if_data, 2));
    exp_q.push_back(mk(1'b1, 1'b0, 32'h48, 1'b1, 3'b001, 32'h5A5A5A5A, exp_d_rdata, 2));
    IF_REQ = 1'b1; D_REQ = 1'b1;
    serve(2, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 2; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL post_reset_grant[%0d]: got %s required %s", i, fmt(o), fmt(e));
      end
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_recover_hold();
    rec_t e, o;
    int gap = 0;
    bit busy_ok = 1'b1;
    ram_lat = 2; ram_hold = 3;
    D_RW = 1'b0; D_ADDR = 32'h80; D_MS = 3'b000; D_WDATA = 32'h12345678;
    D_REQ = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h80, 1'b0, 3'b000, 32'h12345678, exp_d_rdata, 2));
    serve(1, 1'b0, 1'b0);
    ram_hold = 0;
    IF_ADDR = 32'hC;
    IF_REQ = 1'b1;
    exp_if_data = 32'hC ^ K;
    exp_q.push_back(mk(1'b0, 1'b0, 32'hC, 1'b1, 3'b010, 32'h0, exp_if_data, 2));
    do begin
      @(negedge CLK);
      gap++;
      if (gap <= 3 && !BUSY) busy_ok = 1'b0;
    end while (!MEM_MOV && gap < 20);
    vectors++;
    if (gap !== 5) begin
      miscompares++;
      $display("FAIL recover_hold_gap: got %0d cycles to next MOV required 5", gap);
    end
    vectors++;
    if (busy_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL recover_hold_busy: got busy dropped required busy held");
    end
    serve(1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 2; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL recover_hold[%0d]: got %s required %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_round_robin();
    test_timeout();
    test_reset_mid_access();
    test_recover_hold();
    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
